// File: rtl/sensor_hub_core_if.sv
// Bus bundle between the sensor hub core and its UART / DHT11 neighbours.
// The core sits on the master side: it drives the transmit byte/request and
// the per-channel sensor start lines, and samples everything else.
interface sensor_hub_core_if #(
   parameter int N_SENSORS = 4
);
   // UART receiver
   logic [7:0]              i_Rx_Data;
   logic                    i_Rx_Done;
   // UART transmitter
   logic                    i_Tx_Busy;
   logic                    i_Tx_Done;
   logic [7:0]              o_Tx_Data;
   logic                    o_Tx_Start;
   // DHT11 channels, channel k occupies i_Dth_Data[32k+31:32k]
   logic [32*N_SENSORS-1:0] i_Dth_Data;
   logic [N_SENSORS-1:0]    i_Dth_Done;
   logic [N_SENSORS-1:0]    i_Dth_Error;
   logic [N_SENSORS-1:0]    o_Dth_Start;

   modport master (
      input  i_Rx_Data, i_Rx_Done, i_Tx_Busy, i_Tx_Done,
      input  i_Dth_Data, i_Dth_Done, i_Dth_Error,
      output o_Tx_Data, o_Tx_Start, o_Dth_Start
   );

   modport slave (
      output i_Rx_Data, i_Rx_Done, i_Tx_Busy, i_Tx_Done,
      output i_Dth_Data, i_Dth_Done, i_Dth_Error,
      input  o_Tx_Data, o_Tx_Start, o_Dth_Start
   );
endinterface

// File: rtl/sensor_hub_core.sv
// Sensor hub protocol engine: receives a 3-byte request (address, command,
// sensor index) over UART, runs one DHT11 channel read and answers with a
// 1- or 3-byte response. Mismatched addresses are swallowed silently.
module sensor_hub_core #(
   parameter logic [7:0] ADDRESS     = 8'h00,
   parameter int         N_SENSORS   = 4,
   parameter int         RX_TIMEOUT  = 50_000_000,
   parameter int         DTH_TIMEOUT = 100_000_000
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   sensor_hub_core_if.master  bus,
   output logic [3:0]         debug_state
);

   localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

   localparam logic [31:0] RX_LAST  = 32'(RX_TIMEOUT - 1);
   localparam logic [31:0] DTH_LAST = 32'(DTH_TIMEOUT - 1);

   localparam logic [7:0] CMD_STATUS = 8'h03;
   localparam logic [7:0] CMD_TEMP   = 8'h04;
   localparam logic [7:0] CMD_HUM    = 8'h05;

   localparam logic [7:0] RSP_OK      = 8'h00;
   localparam logic [7:0] RSP_HUM     = 8'h01;
   localparam logic [7:0] RSP_TEMP    = 8'h02;
   localparam logic [7:0] RSP_SNS_ERR = 8'h1F;
   localparam logic [7:0] RSP_BAD_CMD = 8'h2F;
   localparam logic [7:0] RSP_BAD_IDX = 8'h3F;
   localparam logic [7:0] RSP_SNS_TMO = 8'h4F;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      RX_CMD       = 4'd1,
      RX_IDX       = 4'd2,
      DISCARD      = 4'd3,
      CHECK        = 4'd4,
      DTH_WAIT     = 4'd5,
      TX_LOAD      = 4'd6,
      TX_WAIT_BUSY = 4'd7,
      TX_WAIT_DONE = 4'd8
   } state_t;

   state_t               state_q;
   logic                 rx_prev_q;
   logic                 tx_prev_q;
   logic [31:0]          rx_cnt_q;
   logic [31:0]          dth_cnt_q;
   logic                 disc_cnt_q;
   logic [7:0]           cmd_q;
   logic [7:0]           idx_q;
   logic [7:0]           code_q;
   logic [7:0]           int_q;
   logic [7:0]           dec_q;
   logic [1:0]           len_q;
   logic [1:0]           byte_cnt_q;
   logic [7:0]           tx_data_q;
   logic                 tx_start_q;
   logic [N_SENSORS-1:0] dth_start_q;

   // Per-channel view of the packed sensor data bus
   logic [31:0] ch_data [N_SENSORS];

   genvar g;
   generate
      for (g = 0; g < N_SENSORS; g++) begin : g_ch
         assign ch_data[g] = bus.i_Dth_Data[32*g +: 32];
      end
   endgenerate

   logic          rx_pulse;
   logic          tx_pulse;
   logic [IW-1:0] idx_sel;
   logic          cmd_ok;
   logic          idx_ok;
   logic          sel_done;
   logic          sel_err;
   logic [31:0]   sel_data;
   logic [7:0]    tx_byte;

   // Both UART strobes are levels; only their rising edges count as events
   assign rx_pulse = bus.i_Rx_Done & ~rx_prev_q;
   assign tx_pulse = bus.i_Tx_Done & ~tx_prev_q;

   // The index is range-checked in CHECK before it is ever used to select a
   // channel, so truncating it to IW bits is safe here.
   assign idx_sel  = idx_q[IW-1:0];
   assign cmd_ok   = (cmd_q == CMD_STATUS) || (cmd_q == CMD_TEMP) || (cmd_q == CMD_HUM);
   assign idx_ok   = (idx_q < 8'(N_SENSORS));
   assign sel_done = bus.i_Dth_Done[idx_sel];
   assign sel_err  = bus.i_Dth_Error[idx_sel];
   assign sel_data = ch_data[idx_sel];

   // Response byte order: code, integral, decimal
   always_comb begin
      tx_byte = code_q;
      case (byte_cnt_q)
         2'd0:    tx_byte = code_q;
         2'd1:    tx_byte = int_q;
         default: tx_byte = dec_q;
      endcase
   end

   // Request/response FSM with registered outputs
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= IDLE;
         rx_prev_q   <= 1'b0;
         tx_prev_q   <= 1'b0;
         rx_cnt_q    <= '0;
         dth_cnt_q   <= '0;
         disc_cnt_q  <= 1'b0;
         cmd_q       <= '0;
         idx_q       <= '0;
         code_q      <= '0;
         int_q       <= '0;
         dec_q       <= '0;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         dth_start_q <= '0;
      end else begin
         rx_prev_q <= bus.i_Rx_Done;
         tx_prev_q <= bus.i_Tx_Done;

         case (state_q)
            IDLE: begin
               if (rx_pulse) begin
                  rx_cnt_q <= '0;
                  if (bus.i_Rx_Data == ADDRESS) begin
                     state_q <= RX_CMD;
                  end else begin
                     disc_cnt_q <= 1'b0;
                     state_q    <= DISCARD;
                  end
               end
            end

            RX_CMD: begin
               if (rx_pulse) begin
                  cmd_q    <= bus.i_Rx_Data;
                  rx_cnt_q <= '0;
                  state_q  <= RX_IDX;
               end else if (rx_cnt_q == RX_LAST) begin
                  state_q <= IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end

            RX_IDX: begin
               if (rx_pulse) begin
                  idx_q    <= bus.i_Rx_Data;
                  rx_cnt_q <= '0;
                  state_q  <= CHECK;
               end else if (rx_cnt_q == RX_LAST) begin
                  state_q <= IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end

            // Frame for another node: swallow command and index bytes
            DISCARD: begin
               if (rx_pulse) begin
                  rx_cnt_q <= '0;
                  if (disc_cnt_q) begin
                     state_q <= IDLE;
                  end else begin
                     disc_cnt_q <= 1'b1;
                  end
               end else if (rx_cnt_q == RX_LAST) begin
                  state_q <= IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end

            // Command is validated before the index; neither error starts a sensor
            CHECK: begin
               byte_cnt_q <= '0;
               dth_cnt_q  <= '0;
               if (!cmd_ok) begin
                  code_q  <= RSP_BAD_CMD;
                  len_q   <= 2'd1;
                  state_q <= TX_LOAD;
               end else if (!idx_ok) begin
                  code_q  <= RSP_BAD_IDX;
                  len_q   <= 2'd1;
                  state_q <= TX_LOAD;
               end else begin
                  dth_start_q <= N_SENSORS'(1) << idx_sel;
                  state_q     <= DTH_WAIT;
               end
            end

            // Error wins over done when both arrive together
            DTH_WAIT: begin
               if (sel_err) begin
                  dth_start_q <= '0;
                  code_q      <= RSP_SNS_ERR;
                  len_q       <= 2'd1;
                  state_q     <= TX_LOAD;
               end else if (sel_done) begin
                  dth_start_q <= '0;
                  state_q     <= TX_LOAD;
                  if (cmd_q == CMD_TEMP) begin
                     code_q <= RSP_TEMP;
                     int_q  <= sel_data[7:0];
                     dec_q  <= sel_data[15:8];
                     len_q  <= 2'd3;
                  end else if (cmd_q == CMD_HUM) begin
                     code_q <= RSP_HUM;
                     int_q  <= sel_data[23:16];
                     dec_q  <= sel_data[31:24];
                     len_q  <= 2'd3;
                  end else begin
                     code_q <= RSP_OK;
                     len_q  <= 2'd1;
                  end
               end else if (dth_cnt_q == DTH_LAST) begin
                  dth_start_q <= '0;
                  code_q      <= RSP_SNS_TMO;
                  len_q       <= 2'd1;
                  state_q     <= TX_LOAD;
               end else begin
                  dth_cnt_q <= dth_cnt_q + 32'd1;
               end
            end

            TX_LOAD: begin
               tx_data_q  <= tx_byte;
               tx_start_q <= 1'b1;
               state_q    <= TX_WAIT_BUSY;
            end

            // Hold the request until the transmitter acknowledges with busy
            TX_WAIT_BUSY: begin
               if (bus.i_Tx_Busy) begin
                  tx_start_q <= 1'b0;
                  state_q    <= TX_WAIT_DONE;
               end
            end

            TX_WAIT_DONE: begin
               if (tx_pulse) begin
                  if (byte_cnt_q + 2'd1 == len_q) begin
                     state_q <= IDLE;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                     state_q    <= TX_LOAD;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_Tx_Data   = tx_data_q;
   assign bus.o_Tx_Start  = tx_start_q;
   assign bus.o_Dth_Start = dth_start_q;
   assign debug_state     = state_q;

endmodule

// File: tb/tb_sensor_hub_core.sv
// Scoreboard bench for sensor_hub_core: directed request frames push their
// expected response bytes; a monitor pops and compares on each transmit
// request. A small UART model answers transmit requests with busy/done.
module tb_sensor_hub_core;
   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dbg;

   always #5 clk = ~clk;

   sensor_hub_core_if #(.N_SENSORS(NS)) bus();

   sensor_hub_core #(
      .ADDRESS(8'h00), .N_SENSORS(NS), .RX_TIMEOUT(20), .DTH_TIMEOUT(100)
   ) dut (
      .i_Clock(clk), .i_Reset(rst), .bus(bus), .debug_state(dbg)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         uart_act = 1'b0;
   bit         dth_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: each rising o_Tx_Start presents one response byte
   initial begin
      logic prev;
      logic [7:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.o_Dth_Start !== '0 && !rst) dth_seen = 1'b1;
         if (bus.o_Tx_Start === 1'b1 && !prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx: got %h expected no byte", bus.o_Tx_Data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", bus.o_Tx_Data, e);
            end
         end
         prev = (bus.o_Tx_Start === 1'b1);
      end
   end

   // UART transmitter model
   initial begin
      bus.i_Tx_Busy = 1'b0;
      bus.i_Tx_Done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.o_Tx_Start === 1'b1) begin
            uart_act = 1'b1;
            bus.i_Tx_Busy = 1'b1;
            repeat (3) @(negedge clk);
            bus.i_Tx_Busy = 1'b0;
            bus.i_Tx_Done = 1'b1;
            repeat (2) @(negedge clk);
            bus.i_Tx_Done = 1'b0;
            @(negedge clk);
            uart_act = 1'b0;
         end
      end
   end

   // Rx_Done held high two cycles; returns with it just dropped
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.i_Rx_Data = b;
      bus.i_Rx_Done = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_Rx_Done = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] i);
      send_byte(a);
      send_byte(c);
      send_byte(i);
   endtask

   task automatic wait_dth(input string name, input logic [NS-1:0] exp);
      int n;
      n = 0;
      while (bus.o_Dth_Start === '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, bus.o_Dth_Start, exp);
   endtask

   task automatic pulse_dth(input int ch, input logic [31:0] data, input logic dn, input logic er);
      @(negedge clk);
      bus.i_Dth_Data[ch*32 +: 32] = data;
      bus.i_Dth_Done[ch]  = dn;
      bus.i_Dth_Error[ch] = er;
      @(negedge clk);
      bus.i_Dth_Done  = '0;
      bus.i_Dth_Error = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(dbg == 4'd0 && exp_q.size() == 0 && !uart_act) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < 3000), 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.i_Rx_Data   = '0;
      bus.i_Rx_Done   = 1'b0;
      bus.i_Dth_Data  = '0;
      bus.i_Dth_Done  = '0;
      bus.i_Dth_Error = '0;
      repeat (3) @(negedge clk);
      check("rst_state", dbg, 4'd0);
      check("rst_tx_start", bus.o_Tx_Start, 1'b0);
      check("rst_tx_data", bus.o_Tx_Data, 8'h00);
      check("rst_dth_start", bus.o_Dth_Start, 4'b0000);
      rst = 1'b0;

      // Temperature on channel 2; a stray done on channel 1 and a stray
      // rx byte during the sensor wait must both be ignored
      exp_q.push_back(8'h02); exp_q.push_back(8'h19); exp_q.push_back(8'h05);
      send_frame(8'h00, 8'h04, 8'h02);
      wait_dth("temp_dth_start", 4'b0100);
      pulse_dth(1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check("other_ch_ignored", bus.o_Dth_Start, 4'b0100);
      send_byte(8'h00);
      check("rx_in_dth_wait", dbg, 4'd5);
      pulse_dth(2, 32'h003C_0519, 1'b1, 1'b0);
      wait_idle("temp_done");
      check("temp_dth_low", bus.o_Dth_Start, 4'b0000);

      // Invalid command
      dth_seen = 1'b0;
      exp_q.push_back(8'h2F);
      send_frame(8'h00, 8'h07, 8'h00);
      wait_idle("badcmd_done");
      check("badcmd_no_dth", 32'(dth_seen), 32'd0);

      // Index out of range
      dth_seen = 1'b0;
      exp_q.push_back(8'h3F);
      send_frame(8'h00, 8'h05, 8'h05);
      wait_idle("badidx_done");
      check("badidx_no_dth", 32'(dth_seen), 32'd0);

      // Other node's frame: silently discarded
      dth_seen = 1'b0;
      send_byte(8'h09);
      check("discard_state", dbg, 4'd3);
      send_byte(8'h04);
      send_byte(8'h00);
      repeat (2) @(negedge clk);
      check("discard_idle", dbg, 4'd0);
      repeat (20) @(negedge clk);
      check("discard_no_dth", 32'(dth_seen), 32'd0);
      wait_idle("discard_done");

      // Sensor timeout: start held exactly DTH_TIMEOUT cycles
      exp_q.push_back(8'h4F);
      send_frame(8'h00, 8'h03, 8'h01);
      wait_dth("tmo_dth_start", 4'b0010);
      n = 0;
      while (bus.o_Dth_Start[1] === 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("tmo_start_cycles", n, 100);
      wait_idle("tmo_done");

      // Done and error together -> sensor error
      exp_q.push_back(8'h1F);
      send_frame(8'h00, 8'h03, 8'h01);
      wait_dth("both_dth_start", 4'b0010);
      pulse_dth(1, 32'h1234_5678, 1'b1, 1'b1);
      wait_idle("both_done");

      // Temperature with sensor error -> only the error byte
      exp_q.push_back(8'h1F);
      send_frame(8'h00, 8'h04, 8'h03);
      wait_dth("temperr_dth_start", 4'b1000);
      pulse_dth(3, 32'h0000_0000, 1'b0, 1'b1);
      wait_idle("temperr_done");

      // Status OK on channel 0
      exp_q.push_back(8'h00);
      send_frame(8'h00, 8'h03, 8'h00);
      wait_dth("status_dth_start", 4'b0001);
      pulse_dth(0, 32'hAAAA_AAAA, 1'b1, 1'b0);
      wait_idle("status_done");

      // Address only: receive timeout back to IDLE, then a normal frame
      send_byte(8'h00);
      repeat (8) @(negedge clk);
      check("rxtmo_waiting", dbg, 4'd1);
      repeat (20) @(negedge clk);
      check("rxtmo_idle", dbg, 4'd0);
      exp_q.push_back(8'h01); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
      send_frame(8'h00, 8'h05, 8'h03);
      wait_dth("hum_dth_start", 4'b1000);
      pulse_dth(3, 32'h1122_3344, 1'b1, 1'b0);
      wait_idle("hum_done");

      // Reset during TX_WAIT_DONE abandons the remaining bytes
      exp_q.push_back(8'h02);
      send_frame(8'h00, 8'h04, 8'h00);
      wait_dth("rst_frame_dth_start", 4'b0001);
      pulse_dth(0, 32'h0000_0A17, 1'b1, 1'b0);
      n = 0;
      while (dbg != 4'd8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_tx_wait_done", dbg, 4'd8);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_state", dbg, 4'd0);
      check("midrst_tx_start", bus.o_Tx_Start, 1'b0);
      check("midrst_tx_data", bus.o_Tx_Data, 8'h00);
      check("midrst_dth_start", bus.o_Dth_Start, 4'b0000);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("midrst_no_more_bytes", exp_q.size(), 0);
      check("midrst_still_idle", dbg, 4'd0);

      // Recovery after reset
      exp_q.push_back(8'h2F);
      send_frame(8'h00, 8'h07, 8'h00);
      wait_idle("recover_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/sensor_hub_core.md
SENSOR_HUB_CORE -- requirements
Module: sensor_hub_core

Interface
REQ-001 Parameter ADDRESS, default 0, 8-bit node address this block answers to.
REQ-002 Parameter N_SENSORS, default 4, number of DHT11 channels, legal range 1..8.
REQ-003 Parameter RX_TIMEOUT, default 50_000_000, max clock cycles between request bytes.
REQ-004 Parameter DTH_TIMEOUT, default 100_000_000, max clock cycles from sensor start to sensor done/error.
REQ-005 i_Clock  in  1  single clock; all logic on rising edge.
REQ-006 i_Reset  in  1  reset, synchronous, active-high.
REQ-007 i_Rx_Data  in  8  byte from UART receiver.
REQ-008 i_Rx_Done  in  1  UART receive complete; level, may stay high several cycles.
REQ-009 i_Tx_Busy  in  1  UART transmitter is shifting a byte.
REQ-010 i_Tx_Done  in  1  UART transmit complete; level.
REQ-011 i_Dth_Data  in  32*N_SENSORS  channel k in bits [32k+31:32k]; per channel [7:0] temp integral, [15:8] temp decimal, [23:16] humidity integral, [31:24] humidity decimal.
REQ-012 i_Dth_Done  in  N_SENSORS  per-channel read complete.
REQ-013 i_Dth_Error  in  N_SENSORS  per-channel sensor error.
REQ-014 o_Tx_Data  out  8  byte to UART transmitter.
REQ-015 o_Tx_Start  out  1  transmit request.
REQ-016 o_Dth_Start  out  N_SENSORS  per-channel read request, one-hot or zero.
REQ-017 debug_state  out  4  current FSM state encoding.

Function
REQ-018 Request frame SHALL be 3 bytes: address, command, sensor index; each byte accepted only on a 0->1 edge of i_Rx_Done (registered previous value).
REQ-019 Valid commands SHALL be 0x03 status, 0x04 temperature, 0x05 humidity.
REQ-020 Responses SHALL be: status -> 1 byte (0x00 ok / 0x1F sensor error / 0x4F sensor timeout); temperature -> 0x02, integral, decimal; humidity -> 0x01, integral, decimal; on sensor error/timeout for 0x04/0x05 only the 1-byte error code is sent.
REQ-021 Invalid command SHALL produce single byte 0x2F; index >= N_SENSORS SHALL produce single byte 0x3F; command check precedes index check; no sensor is started in either case.
REQ-022 Address mismatch SHALL consume the next 2 bytes silently (state DISCARD) and return to IDLE with no transmission.
REQ-023 FSM states SHALL be IDLE, RX_CMD, RX_IDX, DISCARD, CHECK, DTH_WAIT, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE.
REQ-024 Transitions: IDLE->RX_CMD (address match) or DISCARD; RX_CMD->RX_IDX; RX_IDX->CHECK; CHECK->DTH_WAIT (valid) or TX_LOAD (error byte); DTH_WAIT->TX_LOAD; TX_LOAD->TX_WAIT_BUSY->TX_WAIT_DONE->TX_LOAD (bytes remain) or IDLE.
REQ-025 CHECK SHALL last exactly 1 cycle; o_Dth_Start[idx] SHALL rise the cycle after CHECK.
REQ-026 o_Dth_Start[idx] SHALL stay high until i_Dth_Done[idx] or i_Dth_Error[idx] is sampled high, then drop next cycle; other channels' done/error SHALL be ignored.
REQ-027 Done and Error high in same cycle on selected channel SHALL be treated as Error.
REQ-028 Sensor data SHALL be latched from the selected channel slice in the cycle Done is sampled.
REQ-029 DTH_WAIT counter reaching DTH_TIMEOUT SHALL drop o_Dth_Start and respond 0x4F.
REQ-030 In RX_CMD, RX_IDX, DISCARD a counter reaching RX_TIMEOUT without a byte SHALL return to IDLE silently; counter clears on every accepted byte.
REQ-031 TX_LOAD SHALL drive o_Tx_Data and set o_Tx_Start=1; o_Tx_Start SHALL stay 1 until i_Tx_Busy sampled 1, then 0 next cycle.
REQ-032 TX_WAIT_DONE SHALL advance only on 0->1 edge of i_Tx_Done; byte counter (2 bits) selects code/integral/decimal.
REQ-033 Rx bytes arriving in CHECK, DTH_WAIT or any TX state SHALL be discarded, not queued.
REQ-034 o_Tx_Data SHALL hold last loaded byte until next TX_LOAD.

Reset
REQ-035 i_Reset high SHALL, at the next rising edge, force IDLE, o_Tx_Start=0, o_Dth_Start=0, o_Tx_Data=0x00, all counters and latched data 0, edge-detect registers 0.
REQ-036 Reset mid-transaction (including mid-transmit or sensor wait) SHALL abandon the frame with no further output bytes.

Verification
REQ-037 Frame 0x00,0x04,0x02 (ADDRESS=0, N_SENSORS=4), channel 2 Done with data 0x00_3C_05_19 -> o_Dth_Start=0b0100 then bytes 0x02,0x19,0x05.
REQ-038 Frame 0x00,0x07,0x00 -> single byte 0x2F, o_Dth_Start never asserted.
REQ-039 Frame 0x00,0x05,0x05 -> single byte 0x3F; frame 0x09,0x04,0x00 -> no transmission, return to IDLE after third byte.
REQ-040 Frame 0x00,0x03,0x01 with no Done/Error, DTH_TIMEOUT=100 -> o_Dth_Start[1] drops after 100 cycles, byte 0x4F; Done and Error simultaneous on channel 1 -> 0x1F.
REQ-041 Address byte only, RX_TIMEOUT=20 -> IDLE after 20 cycles; next full frame served normally; i_Reset pulsed during TX_WAIT_DONE -> outputs zero next cycle, no further bytes.
